// File: rtl/text_rom_pkg.sv
// Shared definitions for the text-ROM arbiter.
//   arb_state_t       : response-register FSM state encoding
//   STARVE_LIMIT_DEF  : default number of lost conflicts before the data port wins
//   BYTE_ADDR_W       : width of the byte addresses presented on both request ports
//   WORD_OFS_W        : byte-offset bits inside one ROM word (must be zero)
//   addr_err()        : misaligned / out-of-range check for a request address
package text_rom_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int STARVE_LIMIT_DEF = 3;
    localparam int BYTE_ADDR_W      = 32;
    localparam int WORD_OFS_W       = 2;

    // An address is bad when it is not word aligned or when any bit above the
    // ROM's word-address field is set (the word would lie beyond the ROM).
    function automatic logic addr_err(input logic [BYTE_ADDR_W-1:0] addr,
                                      input int unsigned           addr_width);
        logic [BYTE_ADDR_W-1:0] high_bits;
        high_bits = addr >> (addr_width + WORD_OFS_W);
        return (addr[WORD_OFS_W-1:0] != '0) || (high_bits != '0);
    endfunction

endpackage

// File: rtl/rom_rr_grant.sv
// Grant logic plus starvation counter for the two ROM request ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   f_valid    : fetch request valid (already masked by flush)
//   d_valid    : data request valid
//   accept     : the arbiter takes the granted request this cycle
//   grant_f    : fetch port wins this cycle
//   grant_d    : data port wins this cycle
// Fetch normally wins a conflict; once the data port has lost STARVE_LIMIT
// accepted conflicts in a row it wins the next one.
module rom_rr_grant
    import text_rom_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic f_valid,
    input  logic d_valid,
    input  logic accept,
    output logic grant_f,
    output logic grant_d
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;

    always_comb begin
        starved = (starve_cnt_reg == LIMIT);
        grant_d = d_valid & (~f_valid | starved);
        grant_f = f_valid & ~grant_d;
    end

    // Only accepted transfers move the counter; a stalled conflict (no
    // acceptance possible) is not a lost arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (accept) begin
            if (grant_d) begin
                starve_cnt_reg <= '0;
            end else if (grant_f && d_valid && !starved) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_rom_arbiter.sv
// Two-port (instruction fetch / data read) arbiter in front of a
// combinational text ROM, with a single registered response slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   f_req_*  / f_rsp_*  : fetch request / response handshakes
//   d_req_*  / d_rsp_*  : data-read request / response handshakes
//   flush               : pipeline redirect, cancels fetch traffic
//   rom_addr / rom_data : word address to, and read data from, the ROM
// One request is accepted per cycle; its response appears the next cycle
// and is held until the owning port takes it.
module text_rom_arbiter
    import text_rom_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f_req_valid,
    output logic                   f_req_ready,
    input  logic [BYTE_ADDR_W-1:0] f_req_addr,
    output logic                   f_rsp_valid,
    input  logic                   f_rsp_ready,
    output logic [DATA_WIDTH-1:0]  f_rsp_data,
    output logic                   f_rsp_err,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic [BYTE_ADDR_W-1:0] d_req_addr,
    output logic                   d_rsp_valid,
    input  logic                   d_rsp_ready,
    output logic [DATA_WIDTH-1:0]  d_rsp_data,
    output logic                   d_rsp_err,
    input  logic                   flush,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data
);

    arb_state_t              state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg;
    logic [DATA_WIDTH-1:0]   rsp_data_reg;
    logic                    rsp_err_reg;

    logic                    f_valid_eff;
    logic                    grant_f, grant_d;
    logic                    can_accept, accept;
    logic [BYTE_ADDR_W-1:0]  win_addr;
    logic                    win_err;

    // Fetch requests are invisible while flushing.
    assign f_valid_eff = f_req_valid & ~flush;

    rom_rr_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk    (clk),
        .rst_n  (rst_n),
        .f_valid(f_valid_eff),
        .d_valid(d_req_valid),
        .accept (accept),
        .grant_f(grant_f),
        .grant_d(grant_d)
    );

    // The slot frees up in the same cycle its response is consumed, or, for
    // a fetch response, when a flush throws it away. rst_n gates acceptance
    // so that rom_addr and the readies sit at their reset values in reset.
    always_comb begin
        can_accept = 1'b0;
        case (state_reg)
            IDLE:    can_accept = 1'b1;
            BUSY_F:  can_accept = flush | f_rsp_ready;
            BUSY_D:  can_accept = d_rsp_ready;
            default: can_accept = 1'b0;
        endcase
        can_accept = can_accept & rst_n;
    end

    assign accept      = can_accept & (grant_f | grant_d);
    assign f_req_ready = can_accept & grant_f;
    assign d_req_ready = can_accept & grant_d;

    assign win_addr = grant_d ? d_req_addr : f_req_addr;
    assign win_err  = addr_err(win_addr, ADDR_WIDTH);
    assign rom_addr = accept ? win_addr[ADDR_WIDTH+1:2] : rom_addr_reg;

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = grant_d ? BUSY_D : BUSY_F;
        end else if (can_accept) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rom_addr_reg <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rom_addr_reg <= win_addr[ADDR_WIDTH+1:2];
                rsp_data_reg <= win_err ? '0 : rom_data;
                rsp_err_reg  <= win_err;
            end
        end
    end

    // Each port only ever sees its own response; the other reads as zero.
    assign f_rsp_valid = (state_reg == BUSY_F) & ~flush;
    assign d_rsp_valid = (state_reg == BUSY_D);
    assign f_rsp_data  = (state_reg == BUSY_F) ? rsp_data_reg : '0;
    assign f_rsp_err   = (state_reg == BUSY_F) & rsp_err_reg;
    assign d_rsp_data  = (state_reg == BUSY_D) ? rsp_data_reg : '0;
    assign d_rsp_err   = (state_reg == BUSY_D) & rsp_err_reg;

endmodule

// File: tb/tb_text_rom_arbiter.sv
// Directed self-checking bench for text_rom_arbiter. A behavioural ROM
// returns 0xC0DE_0000 | word_address, so ROM[n] = 0xC0DE_0000 + n.
module tb_text_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready;
    logic [31:0] f_req_addr;
    logic        f_rsp_valid, f_rsp_ready;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic        d_req_valid, d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_rsp_valid, d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic        flush;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE_0000 | {22'd0, rom_addr};

    text_rom_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (10),
        .STARVE_LIMIT(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req_valid(f_req_valid),
        .f_req_ready(f_req_ready),
        .f_req_addr (f_req_addr),
        .f_rsp_valid(f_rsp_valid),
        .f_rsp_ready(f_rsp_ready),
        .f_rsp_data (f_rsp_data),
        .f_rsp_err  (f_rsp_err),
        .d_req_valid(d_req_valid),
        .d_req_ready(d_req_ready),
        .d_req_addr (d_req_addr),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_ready(d_rsp_ready),
        .d_rsp_data (d_rsp_data),
        .d_rsp_err  (d_rsp_err),
        .flush      (flush),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d_pattern;
        logic       exp_d;
        d_pattern = 8'b1000_1000;

        rst_n = 1'b0;
        f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b0;
        d_req_valid = 1'b0; d_req_addr = '0; d_rsp_ready = 1'b0;
        flush = 1'b0;

        // Reset state
        #2;
        chk("rst_f_rsp_valid", f_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_f_rsp_data", f_rsp_data, 0);
        chk("rst_d_rsp_err", d_rsp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Single fetch of 0x8 -> ROM[2]
        f_req_valid = 1'b1; f_req_addr = 32'h8; f_rsp_ready = 1'b1;
        #1;
        chk("f1_req_ready", f_req_ready, 1);
        chk("f1_d_req_ready", d_req_ready, 0);
        chk("f1_rom_addr", rom_addr, 2);
        tick();
        f_req_valid = 1'b0;
        chk("f1_rsp_valid", f_rsp_valid, 1);
        chk("f1_rsp_data", f_rsp_data, 32'hC0DE_0002);
        chk("f1_rsp_err", f_rsp_err, 0);
        chk("f1_d_rsp_valid", d_rsp_valid, 0);
        tick();
        chk("f1_rsp_drop", f_rsp_valid, 0);
        $display("fetch 0x8 done");

        // Back-to-back fetch 0x0, 0x4, 0x8
        f_req_valid = 1'b1; f_req_addr = 32'h0;
        tick();
        f_req_addr = 32'h4;
        chk("b2b0_valid", f_rsp_valid, 1);
        chk("b2b0_data", f_rsp_data, 32'hC0DE_0000);
        #1;
        chk("b2b1_req_ready", f_req_ready, 1);
        tick();
        f_req_addr = 32'h8;
        chk("b2b1_valid", f_rsp_valid, 1);
        chk("b2b1_data", f_rsp_data, 32'hC0DE_0001);
        tick();
        f_req_valid = 1'b0;
        chk("b2b2_valid", f_rsp_valid, 1);
        chk("b2b2_data", f_rsp_data, 32'hC0DE_0002);
        tick();
        chk("b2b_end", f_rsp_valid, 0);
        $display("back-to-back fetch done");

        // Both ports valid every cycle: grants F,F,F,D,F,F,F,D
        f_req_valid = 1'b1; f_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h20; d_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_d = d_pattern[i];
            #1;
            chk("arb_f_ready", f_req_ready, !exp_d);
            chk("arb_d_ready", d_req_ready, exp_d);
            tick();
            chk("arb_f_rsp", f_rsp_valid, !exp_d);
            chk("arb_d_rsp", d_rsp_valid, exp_d);
            chk("arb_data", exp_d ? d_rsp_data : f_rsp_data,
                exp_d ? 32'hC0DE_0008 : 32'hC0DE_0004);
            $display("arb cycle %0d grant %s", i, exp_d ? "D" : "F");
        end
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Data errors: out-of-range 0x1000 and misaligned 0x6
        d_req_valid = 1'b1; d_req_addr = 32'h1000;
        #1;
        chk("err1_d_ready", d_req_ready, 1);
        tick();
        d_req_addr = 32'h6;
        chk("err1_valid", d_rsp_valid, 1);
        chk("err1_err", d_rsp_err, 1);
        chk("err1_data", d_rsp_data, 0);
        #1;
        chk("err2_rom_addr", rom_addr, 1);
        tick();
        d_req_valid = 1'b0;
        chk("err2_valid", d_rsp_valid, 1);
        chk("err2_err", d_rsp_err, 1);
        chk("err2_data", d_rsp_data, 0);
        tick();
        chk("err_end", d_rsp_valid, 0);
        $display("data error responses done");

        // Held fetch response, then flush with a pending data request
        f_req_valid = 1'b1; f_req_addr = 32'hC; f_rsp_ready = 1'b0;
        tick();
        f_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", f_rsp_valid, 1);
            chk("hold_data", f_rsp_data, 32'hC0DE_0003);
            tick();
        end
        d_req_valid = 1'b1; d_req_addr = 32'h14; flush = 1'b1;
        #1;
        chk("flush_f_rsp_valid", f_rsp_valid, 0);
        chk("flush_f_req_ready", f_req_ready, 0);
        chk("flush_d_req_ready", d_req_ready, 1);
        tick();
        flush = 1'b0; d_req_valid = 1'b0;
        chk("flush_d_rsp_valid", d_rsp_valid, 1);
        chk("flush_d_rsp_data", d_rsp_data, 32'hC0DE_0005);
        chk("flush_f_gone", f_rsp_valid, 0);
        tick();
        // Flush alone discards a held fetch response for good
        f_req_valid = 1'b1; f_req_addr = 32'h4;
        tick();
        f_req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", f_rsp_valid, 0);
        tick();
        chk("flush_idle2", f_rsp_valid, 0);
        $display("flush sequence done");

        // Reset in the middle of a held data response
        d_req_valid = 1'b1; d_req_addr = 32'h18; d_rsp_ready = 1'b0;
        tick();
        d_req_valid = 1'b0;
        chk("rstmid_busy", d_rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", d_rsp_valid, 0);
        chk("rstmid_data", d_rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstmid_after1", d_rsp_valid, 0);
        tick();
        chk("rstmid_after2", d_rsp_valid, 0);
        $display("mid-transaction reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
